// File: rtl/cmult_seq_5_pkg.sv
// Shared definitions for the sequential complex multiplier controller:
// FSM encoding, product-index constants and default parameter values.
package cmult_seq_5_pkg;

  localparam int DEF_W       = 12;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Product order: re*re, im*im, re*im, im*re
  localparam logic [1:0] K_RR = 2'd0;
  localparam logic [1:0] K_II = 2'd1;
  localparam logic [1:0] K_RI = 2'd2;
  localparam logic [1:0] K_IR = 2'd3;

endpackage

// File: rtl/cmult_seq_5_if.sv
// Start/ready bus between the controller (master) and an external shared
// multiplier (slave).
interface cmult_seq_5_if
  import cmult_seq_5_pkg::*;
#(
  parameter int W = DEF_W
) ();

  logic                  mul_en;
  logic signed [W-1:0]   mul_a;
  logic signed [W-1:0]   mul_b;
  logic signed [2*W-1:0] mul_p;
  logic                  mul_rdy;

  modport master (
    output mul_en, mul_a, mul_b,
    input  mul_p, mul_rdy
  );

  modport slave (
    input  mul_en, mul_a, mul_b,
    output mul_p, mul_rdy
  );

endinterface

// File: rtl/cmult_seq_5.sv
// Complex multiply (a * w) built from four sequential products on a shared
// external multiplier; control FSM, operand registers and accumulators only.
module cmult_seq_5
  import cmult_seq_5_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] w_re,
  input  logic signed [W-1:0] w_im,
  cmult_seq_5_if.master       mul,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [2*W:0] out_re,
  output logic signed [2*W:0] out_im,
  output logic                err,
  input  logic                err_clr
);

  localparam int PW = 2 * W;
  localparam int AW = 2 * W + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t               state_q, state_d;
  logic [1:0]           k_q, k_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [W-1:0]  ar_q, ar_d, ai_q, ai_d, wr_q, wr_d, wi_q, wi_d;
  logic signed [W-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic signed [AW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic                 err_q, err_d;

  logic signed [AW-1:0] prod_ext;
  logic [2*W-1:0]       ops_first, ops_next;

  function automatic logic [2*W-1:0] pick_ops(
    input logic [1:0]          k,
    input logic signed [W-1:0] ar,
    input logic signed [W-1:0] ai,
    input logic signed [W-1:0] wr,
    input logic signed [W-1:0] wi
  );
    logic [2*W-1:0] r;
    case (k)
      K_RR:    r = {ar, wr};
      K_II:    r = {ai, wi};
      K_RI:    r = {ar, wi};
      K_IR:    r = {ai, wr};
      default: r = {ar, wr};
    endcase
    return r;
  endfunction

  assign prod_ext  = {mul.mul_p[PW-1], mul.mul_p};
  assign ops_first = pick_ops(K_RR, a_re, a_im, w_re, w_im);
  assign ops_next  = pick_ops(k_q + 2'd1, ar_q, ai_q, wr_q, wi_q);

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    ar_d     = ar_q;
    ai_d     = ai_q;
    wr_d     = wr_q;
    wi_d     = wi_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    // A timeout in the same cycle overrides the clear below
    err_d    = err_q & ~err_clr;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ar_d               = a_re;
          ai_d               = a_im;
          wr_d               = w_re;
          wi_d               = w_im;
          {mul_a_d, mul_b_d} = ops_first;
          k_d                = K_RR;
          acc_re_d           = '0;
          acc_im_d           = '0;
          state_d            = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul.mul_rdy) begin
          case (k_q)
            K_RR:    acc_re_d = acc_re_q + prod_ext;
            K_II:    acc_re_d = acc_re_q - prod_ext;
            default: acc_im_d = acc_im_q + prod_ext;
          endcase
          if (k_q == K_IR) begin
            state_d = ST_DONE;
          end else begin
            k_d                = k_q + 2'd1;
            {mul_a_d, mul_b_d} = ops_next;
            state_d            = ST_ISSUE;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          k_d     = K_RR;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          k_d     = K_RR;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      cnt_q    <= '0;
      ar_q     <= '0;
      ai_q     <= '0;
      wr_q     <= '0;
      wi_q     <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      ar_q     <= ar_d;
      ai_q     <= ai_d;
      wr_q     <= wr_d;
      wi_q     <= wi_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      err_q    <= err_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign mul.mul_en = (state_q == ST_ISSUE);
  assign mul.mul_a  = mul_a_q;
  assign mul.mul_b  = mul_b_q;
  assign out_re     = acc_re_q;
  assign out_im     = acc_im_q;
  assign err        = err_q;

endmodule

// File: doc/cmult_seq_5.md
CMULT_SEQ_5 -- requirements
Module: cmult_seq_5

Interface
REQ-001 Parameter W, 12, operand width (signed two's complement).
REQ-002 Parameter TIMEOUT, 16, max WAIT cycles per product before abort.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  complex operand set valid.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 a_re, a_im  in  W each  sample real/imag part.
REQ-008 w_re, w_im  in  W each  twiddle real/imag part.
REQ-009 mul_en  out  1  one-cycle start pulse to the shared multiplier.
REQ-010 mul_a, mul_b  out  W each  multiplier operands.
REQ-011 mul_p  in  2W  signed product from multiplier.
REQ-012 mul_rdy  in  1  product valid on mul_p.
REQ-013 out_valid  out  1  complex result valid.
REQ-014 out_ready  in  1  downstream accepts result.
REQ-015 out_re, out_im  out  2W+1 each  signed complex product.
REQ-016 err  out  1  sticky multiplier-timeout flag.
REQ-017 err_clr  in  1  clears err.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-019 in_ready SHALL equal 1 only in IDLE; accept = in_valid & in_ready, operands registered on accept, IDLE->ISSUE, product index k=0, accumulators cleared.
REQ-020 Product order SHALL be k0 a_re*w_re, k1 a_im*w_im, k2 a_re*w_im, k3 a_im*w_re.
REQ-021 ISSUE SHALL last exactly one cycle with mul_en=1 and mul_a/mul_b for product k, then go to WAIT.
REQ-022 mul_a/mul_b SHALL hold the product-k operands from ISSUE until mul_rdy is captured.
REQ-023 mul_rdy SHALL be sampled only in WAIT; mul_rdy in any other state is ignored.
REQ-024 On mul_rdy in WAIT: mul_p sign-extended to 2W+1; k0 add to acc_re, k1 subtract from acc_re, k2/k3 add to acc_im; k<3 -> ISSUE with k+1, k=3 -> DONE.
REQ-025 With multiplier latency Lm (mul_rdy Lm cycles after mul_en), out_valid SHALL rise 4*Lm+5 cycles after the accept cycle.
REQ-026 In DONE, out_valid=1 and out_re/out_im hold stable until out_valid & out_ready, then IDLE; no new accept in the same cycle.
REQ-027 out_re/out_im SHALL be exact (no rounding/saturation); full-scale inputs cannot overflow 2W+1 bits.
REQ-028 WAIT cycle counter SHALL reset on entry to WAIT; if TIMEOUT cycles pass without mul_rdy: err<=1, FSM->IDLE, no out_valid for that operand set.
REQ-029 err SHALL clear on err_clr; if timeout and err_clr coincide, err SHALL be 1.
REQ-030 Outside ISSUE mul_en SHALL be 0.

Reset
REQ-031 On rst: state IDLE, in_ready=1 on the next cycle, mul_en=0, mul_a=mul_b=0, out_valid=0, out_re=out_im=0, err=0, k=0, counter=0.
REQ-032 rst mid-operation SHALL abort silently; any later mul_rdy from the aborted product is ignored.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding, the product-index constants, and the default W/TIMEOUT values.
REQ-034 The block SHALL be pure control plus accumulators; no multiplier inside, no sub-module required.

Verification
REQ-035 Lm=1 model: a=(100,50), w=(200,-30) -> out=(21500,7000), out_valid 9 cycles after accept, exactly 4 mul_en pulses.
REQ-036 Full scale: a=(-2048,-2048), w=(-2048,-2048) -> out=(0,8388608).
REQ-037 Back-pressure: out_ready held 0 for 5 cycles -> out_valid and data stable, in_ready=0; release -> IDLE next cycle.
REQ-038 Multiplier never asserts mul_rdy (TIMEOUT=16) -> err=1 after 16 WAIT cycles, FSM returns to IDLE, no out_valid; err_clr -> err=0.
REQ-039 rst asserted in WAIT of k2, stray mul_rdy after rst -> all outputs at reset values; next operand set computes correctly.
REQ-040 Variable latency Lm=0..5 per product, random operands (1000 sets) -> results match a signed reference model.
